// File: rtl/gigatron_ram_arbiter.sv
// gigatron_ram_arbiter: shares the single asynchronous SRAM between the
// Gigatron CPU and a host port (debug/loader/SPI bridge).
// The CPU always owns the SRAM pins and is never stalled. A host access is
// only slotted into a CPU cycle that neither reads nor stores RAM.
// Optional build macro: GIGATRON_ARB_ERR_EN adds a PEND wait counter that
// aborts a host access after TIMEOUT non-granted cycles (TIMEOUT=0: never).
module gigatron_ram_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  input  logic          cpu_oe_n,
  input  logic          cpu_we,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          host_ack,
  output logic          host_err,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          ram_oe_n,
  output logic          ram_we_n
);

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

  state_t        r_state;
  logic          r_h_we;
  logic [AW-1:0] r_h_addr;
  logic [7:0]    r_h_wdata;
  logic [7:0]    r_host_rdata;
  logic          r_host_ack;

  logic          w_cpu_idle;
  logic          w_grant;

  assign w_cpu_idle = cpu_oe_n & ~cpu_we;
  assign w_grant    = (r_state == PEND) & w_cpu_idle;

`ifdef GIGATRON_ARB_ERR_EN
  logic [7:0] r_wcnt;
  logic [7:0] w_wcnt_next;
  logic       w_timeout;
  logic       r_host_err;

  // Saturating wait count; the timeout fires on the cycle the count would
  // reach TIMEOUT, i.e. after TIMEOUT consecutive non-granted PEND cycles.
  // A TIMEOUT above 255 can never be reached and behaves like "never".
  assign w_wcnt_next = (r_wcnt == 8'hFF) ? 8'hFF : r_wcnt + 8'd1;
  assign w_timeout   = (TIMEOUT != 0) && (32'(w_wcnt_next) == TIMEOUT);
  assign host_err    = r_host_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT == 0);
  assign host_err         = 1'b0;
`endif

  assign host_rdata = r_host_rdata;
  assign host_ack   = r_host_ack;

  // CPU read data is a pure passthrough: no registers on the CPU path.
  assign cpu_rdata = ram_rdata;

  // Host access FSM: latch the request, wait for an idle CPU cycle, ack once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_h_we       <= 1'b0;
      r_h_addr     <= '0;
      r_h_wdata    <= '0;
      r_host_rdata <= '0;
      r_host_ack   <= 1'b0;
`ifdef GIGATRON_ARB_ERR_EN
      r_wcnt       <= '0;
      r_host_err   <= 1'b0;
`endif
    end else begin
      r_host_ack <= 1'b0;
`ifdef GIGATRON_ARB_ERR_EN
      r_host_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
`ifdef GIGATRON_ARB_ERR_EN
          r_wcnt <= '0;
`endif
          if (host_req) begin
            r_h_we    <= host_we;
            r_h_addr  <= host_addr;
            r_h_wdata <= host_wdata;
            r_state   <= PEND;
          end
        end
        PEND: begin
          if (w_grant) begin
            if (!r_h_we) begin
              r_host_rdata <= ram_rdata;
            end
            r_host_ack <= 1'b1;
            r_state    <= DONE;
          end
`ifdef GIGATRON_ARB_ERR_EN
          else begin
            r_wcnt <= w_wcnt_next;
            if (w_timeout) begin
              r_host_ack <= 1'b1;
              r_host_err <= 1'b1;
              r_state    <= DONE;
            end
          end
`endif
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // SRAM pin mux. Writes strobe low only in the second (clk-low) half so the
  // address is stable across the whole strobe. Reset forces IDLE, which hands
  // the pins straight back to the CPU without waiting for a clock edge.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_oe_n  = cpu_oe_n;
    ram_we_n  = cpu_we ? clk : 1'b1;
    if (w_grant) begin
      ram_addr  = r_h_addr;
      ram_wdata = r_h_wdata;
      ram_oe_n  = r_h_we;
      ram_we_n  = r_h_we ? clk : 1'b1;
    end
  end

endmodule

// File: tb/tb_gigatron_ram_arbiter.sv
// Bench for gigatron_ram_arbiter. The bench owns the SRAM model and a
// reference memory image; host transactions are predicted at transaction
// level: the host access lands on the first CPU-idle cycle after acceptance
// and is acknowledged on the following cycle.
`timescale 1ns/1ps
module tb_gigatron_ram_arbiter;
  localparam int unsigned AW = 16;
`ifdef GIGATRON_ARB_ERR_EN
  localparam int TO = 4;
`else
  localparam int TO = 0;
`endif

  logic          clk;
  logic          reset;
  logic [AW-1:0] cpu_addr, host_addr, ram_addr;
  logic [7:0]    cpu_wdata, cpu_rdata, host_wdata, host_rdata, ram_wdata, ram_rdata;
  logic          cpu_oe_n, cpu_we, host_req, host_we, host_ack, host_err, ram_oe_n, ram_we_n;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] exp_hrdata;
  int n_cmp = 0;
  int n_err = 0;

  gigatron_ram_arbiter #(.TIMEOUT(4), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_oe_n(cpu_oe_n), .cpu_we(cpu_we),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .host_err(host_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: drives data only while output-enabled.
  assign ram_rdata = ram_oe_n ? 8'hEE : mem[ram_addr];

  // Write commits late in the low half while the strobe is low.
  always @(negedge clk) begin
    #2;
    if (ram_we_n === 1'b0) mem[ram_addr] = ram_wdata;
  end

  task automatic set_cpu(input int kind, input logic [15:0] a, input logic [7:0] d);
    cpu_oe_n  = (kind != 1);
    cpu_we    = (kind == 2);
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  // One host transaction from acceptance to the IDLE cycle after the ack.
  // Called at posedge+1 with the DUT idle; returns at posedge+1, DUT idle.
  // CPU op kinds: 0 idle, 1 read, 2 store.
  task automatic host_xact(input logic we, input logic [15:0] a, input logic [7:0] d,
                           input int busy_n, input int idle_pct, input logic busy_rd,
                           input logic do_st, input logic [7:0] st_d,
                           input logic drop_req, input string tag);
    int phase, k, kind;
    logic grant, aborted, e_ack, e_err, e_oe, e_we;
    logic [15:0] ca, e_addr;
    logic [7:0]  cd, e_wd;
    phase = 0; k = 0; aborted = 1'b0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    while (phase < 4) begin
      grant = 1'b0;
      ca = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      cd = 8'($urandom);
      kind = ($urandom_range(0, 99) < idle_pct) ? 0 : int'($urandom_range(1, 2));
      if (phase == 1) begin
        k++;
        if (do_st && k == 1) begin kind = 2; ca = a; cd = st_d; end
        else if (k <= busy_n) kind = busy_rd ? 1 : int'($urandom_range(1, 2));
        else if (k > busy_n + 16) kind = 0;
        grant = (kind == 0);
        if (drop_req && k == 1) begin
          host_req = 1'b0; host_we = ~we; host_addr = ~a; host_wdata = ~d;
        end
      end
      if (phase == 3) host_req = 1'b0;
      set_cpu(kind, ca, cd);
      #1;
      e_addr = grant ? a : ca;
      e_wd   = grant ? d : cd;
      e_oe   = grant ? we : (kind != 1);
      e_we   = grant ? we : (kind == 2);
      e_ack  = (phase == 2);
      e_err  = (phase == 2) && aborted;
      n_cmp++;
      if ({ram_addr, ram_wdata, ram_oe_n, ram_we_n} !== {e_addr, e_wd, e_oe, 1'b1}) begin
        n_err++;
        $display("FAIL %s ph%0d ram_bus_high: got addr=%h wd=%h oe_n=%b we_n=%b expected addr=%h wd=%h oe_n=%b we_n=1",
                 tag, phase, ram_addr, ram_wdata, ram_oe_n, ram_we_n, e_addr, e_wd, e_oe);
      end
      n_cmp++;
      if ({host_ack, host_err} !== {e_ack, e_err}) begin
        n_err++;
        $display("FAIL %s ph%0d ack_err: got %b%b expected %b%b", tag, phase, host_ack, host_err, e_ack, e_err);
      end
      n_cmp++;
      if (host_rdata !== exp_hrdata) begin
        n_err++;
        $display("FAIL %s ph%0d host_rdata: got %h expected %h", tag, phase, host_rdata, exp_hrdata);
      end
      if (kind == 1) begin
        n_cmp++;
        if (cpu_rdata !== ref_mem[ca]) begin
          n_err++;
          $display("FAIL %s ph%0d cpu_rdata @%h: got %h expected %h", tag, phase, ca, cpu_rdata, ref_mem[ca]);
        end
      end
      @(negedge clk); #1;
      n_cmp++;
      if (ram_we_n !== ~e_we) begin
        n_err++;
        $display("FAIL %s ph%0d ram_we_n_low_half: got %b expected %b", tag, phase, ram_we_n, ~e_we);
      end
      if (grant) begin
        if (we) ref_mem[a] = d;
        else    exp_hrdata = ref_mem[a];
      end
      if (kind == 2) ref_mem[ca] = cd;
      @(posedge clk); #1;
      if (phase == 1) begin
        if (grant) phase = 2;
        else if (TO != 0 && k == TO) begin aborted = 1'b1; phase = 2; end
      end else begin
        phase++;
      end
    end
  endtask

  task automatic test_reset();
    int kind;
    logic [15:0] ca;
    logic [7:0]  cd;
    reset = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 16'h4444; host_wdata = 8'h99;
    exp_hrdata = '0;
    for (int i = 0; i < 4; i++) begin
      kind = int'($urandom_range(0, 2));
      ca = 16'($urandom); cd = 8'($urandom);
      set_cpu(kind, ca, cd);
      #1;
      n_cmp++;
      if ({host_ack, host_err, host_rdata} !== 10'b0) begin
        n_err++;
        $display("FAIL reset host_outs: got ack=%b err=%b rdata=%h expected 0/0/00", host_ack, host_err, host_rdata);
      end
      n_cmp++;
      if ({ram_addr, ram_wdata, ram_oe_n, ram_we_n} !== {ca, cd, (kind != 1), 1'b1}) begin
        n_err++;
        $display("FAIL reset ram_mirror: got addr=%h wd=%h oe_n=%b we_n=%b expected addr=%h wd=%h",
                 ram_addr, ram_wdata, ram_oe_n, ram_we_n, ca, cd);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (ram_we_n !== (kind != 2)) begin
        n_err++;
        $display("FAIL reset ram_we_n: got %b expected %b", ram_we_n, (kind != 2));
      end
      if (kind == 2) ref_mem[ca] = cd;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    host_xact(1'b0, 16'($urandom), 8'h00, 0, 100, 1'b0, 1'b0, 8'h00, 1'b0, "reset_release");
  endtask

  task automatic test_read_idle();
    mem[16'h0123] = 8'h5A; ref_mem[16'h0123] = 8'h5A;
    host_xact(1'b0, 16'h0123, 8'h00, 0, 100, 1'b0, 1'b0, 8'h00, 1'b0, "read_idle");
    n_cmp++;
    if (exp_hrdata !== 8'h5A || host_rdata !== 8'h5A) begin
      n_err++;
      $display("FAIL read_idle value: got %h expected 5a", host_rdata);
    end
  endtask

  task automatic test_write_cpu_busy();
    host_xact(1'b1, 16'h8000, 8'hC3, 10, 100, 1'b1, 1'b0, 8'h00, 1'b0, "write_busy");
    n_cmp++;
    if (mem[16'h8000] !== 8'hC3) begin
      n_err++;
      $display("FAIL write_busy sram_8000: got %h expected c3", mem[16'h8000]);
    end
  endtask

  task automatic test_store_collision();
    host_xact(1'b0, 16'h0010, 8'h00, 1, 100, 1'b0, 1'b1, 8'h11, 1'b0, "store_collision");
    n_cmp++;
    if (host_rdata !== 8'h11) begin
      n_err++;
      $display("FAIL store_collision rdata: got %h expected 11", host_rdata);
    end
  endtask

  task automatic test_drop_req();
    host_xact(1'b1, 16'h0400, 8'h3C, 2, 50, 1'b0, 1'b0, 8'h00, 1'b1, "drop_req");
    host_xact(1'b0, 16'h0400, 8'h00, 0, 30, 1'b0, 1'b0, 8'h00, 1'b1, "drop_req_rd");
  endtask

`ifdef GIGATRON_ARB_ERR_EN
  task automatic test_timeout();
    host_xact(1'b0, 16'($urandom), 8'h00, 10, 100, 1'b0, 1'b0, 8'h00, 1'b0, "timeout_abort");
    host_xact(1'b1, 16'h0300, 8'hA5, 10, 100, 1'b0, 1'b0, 8'h00, 1'b0, "timeout_wr_abort");
    host_xact(1'b0, 16'h0300, 8'h00, 3, 100, 1'b0, 1'b0, 8'h00, 1'b0, "timeout_grant_wins");
  endtask
`endif

  task automatic test_reset_mid_pend();
    logic [7:0] old;
    old = ref_mem[16'h0200];
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0200; host_wdata = ~old;
    set_cpu(1, 16'h1234, 8'h00);
    @(posedge clk); #1;
    set_cpu(1, 16'h1235, 8'h00);
    @(posedge clk); #1;
    set_cpu(0, 16'h2222, 8'h77);
    #1;
    n_cmp++;
    if (ram_addr !== 16'h0200) begin
      n_err++;
      $display("FAIL reset_mid_pend grant: got addr=%h expected 0200", ram_addr);
    end
    #1; reset = 1'b1; #1;
    n_cmp++;
    if ({ram_addr, ram_oe_n, host_ack} !== {16'h2222, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_pend release: got addr=%h oe_n=%b ack=%b expected 2222/1/0",
               ram_addr, ram_oe_n, host_ack);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (ram_we_n !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_pend we_n: got %b expected 1", ram_we_n);
    end
    host_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; exp_hrdata = '0;
    @(negedge clk); #3;
    n_cmp++;
    if (mem[16'h0200] !== old) begin
      n_err++;
      $display("FAIL reset_mid_pend sram_0200: got %h expected %h", mem[16'h0200], old);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (host_ack !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_pend late_ack: got %b expected 0", host_ack);
    end
    host_xact(1'b0, 16'h0200, 8'h00, 0, 100, 1'b0, 1'b0, 8'h00, 1'b0, "read_after_reset");
  endtask

  task automatic test_random_traffic();
    for (int n = 0; n < 40; n++) begin
      host_xact(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                int'($urandom_range(0, 6)), int'($urandom_range(20, 80)), 1'b0,
                ($urandom_range(0, 3) == 0), 8'($urandom),
                ($urandom_range(0, 3) == 0), "random");
    end
  endtask

  task automatic test_mem_image();
    int bad;
    bad = 0;
    for (int i = 0; i < 65536; i++) begin
      if (mem[i] !== ref_mem[i]) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL mem_image: got %0d differing bytes expected 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    reset = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    set_cpu(0, 16'h0000, 8'h00);
    exp_hrdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_read_idle();
    test_write_cpu_busy();
    test_store_collision();
    test_drop_req();
`ifdef GIGATRON_ARB_ERR_EN
    test_timeout();
`endif
    test_reset_mid_pend();
    test_random_traffic();
    test_mem_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gigatron_ram_arbiter.md
Name: gigatron_ram_arbiter

Overview:
- Shares the single asynchronous SRAM between the Gigatron CPU and a host port, such as a debug, loader or SPI bridge.
- The CPU has absolute priority and is never stalled; video timing depends on this.
- Host accesses are slotted into CPU cycles that do not touch RAM.
- Sits between the CPU core's RAM pins (addr/bus/oe_n/store) and the board SRAM pins.

Parameters:
TIMEOUT, 255, PEND cycles before host access is aborted (only with GIGATRON_ARB_ERR_EN; 0 = never abort)
AW, 16, SRAM address width; CPU and host addresses use bits [AW-1:0]

Ports:
clk  in  1  system clock, CPU cycle clock
reset  in  1  asynchronous, active-high reset
cpu_addr  in  AW  CPU RAM address
cpu_wdata  in  8  CPU store data
cpu_rdata  out  8  RAM read data to CPU
cpu_oe_n  in  1  CPU RAM read this cycle (active low)
cpu_we  in  1  CPU store this cycle (active high)
host_req  in  1  host request level, held until host_ack
host_we  in  1  1 = write, 0 = read; sampled with host_req
host_addr  in  AW  host address
host_wdata  in  8  host write data
host_rdata  out  8  host read data, valid while host_ack=1
host_ack  out  1  one-cycle completion pulse
host_err  out  1  with host_ack, access aborted by timeout
ram_addr  out  AW  SRAM address
ram_wdata  out  8  SRAM write data (board tristate uses ram_we_n)
ram_rdata  in  8  SRAM read data
ram_oe_n  out  1  SRAM output enable
ram_we_n  out  1  SRAM write strobe

Behaviour:
- cpu_idle = cpu_oe_n & ~cpu_we (combinational).
- FSM states: IDLE, PEND, DONE. Reset state is IDLE.
- IDLE:
  - host_req=1 → latch host_we/addr/wdata into h_we/h_addr/h_wdata and go to PEND.
  - Clear the wait counter wcnt to 0.
- PEND:
  - grant = cpu_idle (combinational, this cycle).
  - grant=1 → ram_addr=h_addr, ram_wdata=h_wdata.
    - Read: ram_oe_n=0, ram_we_n=1.
    - Write: ram_oe_n=1, ram_we_n=clk (low in second half of cycle only).
  - At the granted edge:
    - Read: host_rdata ← ram_rdata.
    - Go to DONE.
  - No grant → wcnt increments, saturating at 2^8-1.
- DONE:
  - host_ack=1 for exactly one cycle.
  - Always return to IDLE.
  - A host_req still high in DONE is ignored.
  - A new request is accepted from the next IDLE cycle; minimum 3 cycles per host access.
- Non-granted cycles: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_oe_n=cpu_oe_n, ram_we_n = cpu_we ? clk : 1.
- cpu_rdata = ram_rdata always (combinational passthrough, zero latency). The CPU path has no registers.
- CPU collision: never. Grant requires cpu_idle, so CPU timing is identical with or without host traffic.
- Same-address CPU store and pending host read: the host read sees the CPU value once granted later (program order by grant).
- Registered outputs host_ack, host_err and host_rdata reset to 0. host_rdata holds its last value between reads; unchanged by writes.
- Latched h_* registers reset to 0.
- Reset mid-PEND or mid-DONE: access discarded, no ack, and the SRAM returns to CPU control immediately (asynchronously). A host write that has not yet been granted is never performed.
- host_req deasserted while in PEND: the access still completes; the host must tolerate the late ack.

Optional Feature:
- Macro: GIGATRON_ARB_ERR_EN.
- Defined:
  - In PEND with TIMEOUT≠0, when wcnt reaches TIMEOUT without a grant → DONE with host_ack=1, host_err=1.
  - No RAM access occurs and host_rdata is unchanged.
  - A grant in the same cycle as the timeout wins: normal completion, host_err=0.
- Undefined:
  - No counter logic; wcnt is removed.
  - host_err is tied 0.
  - PEND waits indefinitely.

Test Plan:
- Reset with host_req=1: host_ack=0, host_rdata=0, ram_* mirror the CPU inputs; after release the request is accepted 1 cycle later.
- Host read 0x0123, RAM holds 0x5A, cpu_oe_n=1 and cpu_we=0 throughout → ram_addr=0x0123 in cycle 2; host_ack with host_rdata=0x5A in cycle 3.
- Host write 0x8000←0xC3 while CPU reads for 10 cycles → no grant, ram_addr follows cpu_addr; first idle cycle writes 0xC3 (ram_we_n low in second half); ack on the following cycle; CPU data is never corrupted.
- CPU store to 0x0010 = 0x11 in the cycle a host read of 0x0010 is pending → host waits; next idle cycle returns 0x11.
- With GIGATRON_ARB_ERR_EN, TIMEOUT=4, CPU busy continuously → host_ack=host_err=1 after 4 PEND cycles; a grant coinciding with the timeout gives host_err=0.
- Reset asserted during PEND of a host write to 0x0200 → 0x0200 is unchanged, no ack, FSM returns to IDLE.
